tile_store_dma: RTL and testbench

TILE_STORE_DMA -- requirements
Module: tile_store_dma

---
 rtl/tile_dma_pkg.sv | 17 +
 rtl/dma_out_fifo.sv | 83 ++++++++
 rtl/tile_store_dma.sv | 151 +++++++++++++++
 tb/tb_tile_store_dma.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tile_dma_pkg.sv
// Shared types and helpers for the tile load/store DMA engines.
package tile_dma_pkg;

    // Engine control states: idle, streaming a tile, one-cycle completion.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } dma_state_e;

    // Output buffer depth needed so that every read in flight has a slot
    // waiting for it: RD_LAT words in flight plus two for full throughput.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/dma_out_fifo.sv
// Small output FIFO between the BRAM read pipe and the host stream.
// Storage is registered; head always presents the oldest entry.
module dma_out_fifo #(
    parameter int W          = 16,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr,
    input  logic                              push,
    input  logic [W-1:0]                      push_data,
    input  logic                              pop,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   occ,
    output logic [W-1:0]                      head
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [W-1:0]  mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          do_pop_s;

    // Pointer advance with wrap at a depth that need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Next-state for storage, pointers and occupancy; push and pop may coincide.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        do_pop_s = pop && (occ_q != '0);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            occ_d = occ_q + OW'(push) - OW'(do_pop_s);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/tile_store_dma.sv
// Streams one tile from a double-buffered BRAM to a ready/valid host port.
// Reads are issued only when the output FIFO is guaranteed room for them,
// so returning BRAM data never needs a stall path.
module tile_store_dma
    import tile_dma_pkg::*;
#(
    parameter int W      = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_store,
    input  logic                       buf_sel,
    output logic                       bram_re,
    output logic [$clog2(DEPTH):0]     bram_raddr,
    input  logic [W-1:0]               bram_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       store_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FD = fifo_depth(RD_LAT);
    localparam int OW = $clog2(FD + 1);
    localparam logic [OW:0] FD_LIM = (OW + 1)'(FD);

    dma_state_e        state_q, state_d;
    logic              sel_q, sel_d;
    logic [CW-1:0]     issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]     accept_cnt_q, accept_cnt_d;
    logic [OW-1:0]     inflight_q, inflight_d;
    logic [RD_LAT-1:0] rv_q, rv_d;

    logic [OW-1:0]     fifo_occ_s;
    logic [W-1:0]      fifo_head_s;
    logic              fifo_clr_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              valid_s;
    logic              last_s;

    // Issue/push/pop decisions and stream flags, from registered state only.
    always_comb begin
        issue_s    = (state_q == S_RUN) && !issue_cnt_q[AW] &&
                     (({1'b0, fifo_occ_s} + {1'b0, inflight_q}) < FD_LIM);
        push_s     = rv_q[RD_LAT-1];
        valid_s    = (fifo_occ_s != '0);
        last_s     = valid_s && (accept_cnt_q == CW'(DEPTH - 1));
        pop_s      = valid_s && out_ready;
        fifo_clr_s = (state_q == S_IDLE) && start_store;
    end

    // FSM next-state, counters and read-valid pipe tracking BRAM latency.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        issue_cnt_d  = issue_cnt_q;
        accept_cnt_d = accept_cnt_q;
        inflight_d   = inflight_q;
        rv_d[0]      = issue_s;
        for (int i = 1; i < RD_LAT; i++) begin
            rv_d[i] = rv_q[i-1];
        end
        case (state_q)
            S_IDLE: begin
                if (start_store) begin
                    state_d      = S_RUN;
                    sel_d        = buf_sel;
                    issue_cnt_d  = '0;
                    accept_cnt_d = '0;
                    inflight_d   = '0;
                    rv_d         = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (issue_s) begin
                    issue_cnt_d = issue_cnt_q + CW'(1);
                end else begin
                    issue_cnt_d = issue_cnt_q;
                end
                inflight_d = inflight_q + OW'(issue_s) - OW'(push_s);
                if (pop_s) begin
                    accept_cnt_d = accept_cnt_q + CW'(1);
                end else begin
                    accept_cnt_d = accept_cnt_q;
                end
                if (pop_s && last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers; reset also flushes reads still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sel_q        <= 1'b0;
            issue_cnt_q  <= '0;
            accept_cnt_q <= '0;
            inflight_q   <= '0;
            rv_q         <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            issue_cnt_q  <= issue_cnt_d;
            accept_cnt_q <= accept_cnt_d;
            inflight_q   <= inflight_d;
            rv_q         <= rv_d;
        end
    end

    dma_out_fifo #(
        .W          (W),
        .FIFO_DEPTH (FD)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (fifo_clr_s),
        .push      (push_s),
        .push_data (bram_rdata),
        .pop       (pop_s),
        .occ       (fifo_occ_s),
        .head      (fifo_head_s)
    );

    assign bram_re    = issue_s;
    assign bram_raddr = {sel_q, issue_cnt_q[AW-1:0]};
    assign out_valid  = valid_s;
    assign out_data   = fifo_head_s;
    assign out_last   = last_s;
    assign busy       = (state_q != S_IDLE);
    assign store_done = (state_q == S_DONE);

endmodule

// File: tb/tb_tile_store_dma.sv
// Directed bench for tile_store_dma: DEPTH=8, BRAM word[a]=a+0x100,
// one instance with RD_LAT=1 and one with RD_LAT=3.
module tb_tile_store_dma;

    logic clk = 1'b0;
    logic rst_n;
    logic start_s;
    logic use3;
    logic buf_sel;
    logic out_ready;

    logic        start1, start3;
    logic        re1, re3, valid1, valid3, last1, last3, busy1, busy3, done1, done3;
    logic [3:0]  raddr1, raddr3;
    logic [15:0] rdata1, rdata3, data1, data3;

    logic        re_m, valid_m, last_m, busy_m, done_m;
    logic [3:0]  raddr_m;
    logic [15:0] data_m;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    logic [15:0] got_q[$];
    logic [3:0]  ra_q[$];
    int          acc_q[$];
    int          last_idx, first_valid, first_re, done_cyc, done_cnt, held_bad, stall_re;
    logic        busy_c1;

    always #5 clk = ~clk;

    assign start1 = start_s & ~use3;
    assign start3 = start_s & use3;

    assign re_m    = use3 ? re3    : re1;
    assign raddr_m = use3 ? raddr3 : raddr1;
    assign valid_m = use3 ? valid3 : valid1;
    assign data_m  = use3 ? data3  : data1;
    assign last_m  = use3 ? last3  : last1;
    assign busy_m  = use3 ? busy3  : busy1;
    assign done_m  = use3 ? done3  : done1;

    tile_store_dma #(.W(16), .DEPTH(8), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_store(start1), .buf_sel(buf_sel),
        .bram_re(re1), .bram_raddr(raddr1), .bram_rdata(rdata1),
        .out_valid(valid1), .out_ready(out_ready), .out_data(data1),
        .out_last(last1), .busy(busy1), .store_done(done1)
    );

    tile_store_dma #(.W(16), .DEPTH(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_store(start3), .buf_sel(buf_sel),
        .bram_re(re3), .bram_raddr(raddr3), .bram_rdata(rdata3),
        .out_valid(valid3), .out_ready(out_ready), .out_data(data3),
        .out_last(last3), .busy(busy3), .store_done(done3)
    );

    // BRAM model, latency 1: data valid in the cycle after the read enable.
    logic       re1_p;
    logic [3:0] a1_p;
    always @(posedge clk) begin
        re1_p <= re1;
        a1_p  <= raddr1;
    end
    assign rdata1 = re1_p ? (16'h0100 + {12'h000, a1_p}) : 16'hDEAD;

    // BRAM model, latency 3.
    logic [2:0] re3_p;
    logic [3:0] a3_p [3];
    always @(posedge clk) begin
        re3_p   <= {re3_p[1:0], re3};
        a3_p[0] <= raddr3;
        a3_p[1] <= a3_p[0];
        a3_p[2] <= a3_p[1];
    end
    assign rdata3 = re3_p[2] ? (16'h0100 + {12'h000, a3_p[2]}) : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts a tile and observes it cycle by cycle; cycle 1 follows the
    // edge that samples start_store. Returns early after stop_words accepts.
    task automatic run_tile(input logic sel, input int bp_lo, input int bp_hi,
                            input int restart_cyc, input int stop_words);
        logic [15:0] exp_head;
        got_q.delete(); ra_q.delete(); acc_q.delete();
        last_idx = -1; first_valid = -1; first_re = -1; done_cyc = -1;
        done_cnt = 0; held_bad = 0; stall_re = 0; busy_c1 = 1'b0;
        buf_sel   = sel;
        out_ready = 1'b1;
        start_s   = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 60; c++) begin
            out_ready = !(c >= bp_lo && c <= bp_hi);
            start_s   = (c == restart_cyc);
            #1;
            if (c == 1) busy_c1 = busy_m;
            if (re_m) begin
                ra_q.push_back(raddr_m);
                if (first_re < 0) first_re = c;
                if (bp_lo > 0 && c > bp_lo && c <= bp_hi) stall_re++;
            end
            if (valid_m && first_valid < 0) first_valid = c;
            exp_head = 16'h0100 + (sel ? 16'h0008 : 16'h0000) + 16'(got_q.size());
            if (valid_m && !out_ready && data_m !== exp_head) held_bad++;
            if (valid_m && out_ready) begin
                if (last_m) last_idx = got_q.size();
                got_q.push_back(data_m);
                acc_q.push_back(c);
            end
            if (done_m) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (stop_words > 0 && got_q.size() == stop_words) begin
                start_s = 1'b0;
                return;
            end
            if (done_cyc > 0 && c >= done_cyc + 2) break;
            @(posedge clk); #1;
        end
        start_s   = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_words(input string tag, input logic [15:0] base);
        check({tag, "_count"}, 32'(got_q.size()), 32'd8);
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            check($sformatf("%s_word%0d", tag, i), {16'h0, got_q[i]}, {16'h0, base + 16'(i)});
        end
    endtask

    initial begin
        rst_n = 1'b0; start_s = 1'b0; use3 = 1'b0; buf_sel = 1'b0; out_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_bram_re",    {31'h0, re_m},    32'h0);
        check("rst_raddr",      {28'h0, raddr_m}, 32'h0);
        check("rst_out_valid",  {31'h0, valid_m}, 32'h0);
        check("rst_out_last",   {31'h0, last_m},  32'h0);
        check("rst_busy",       {31'h0, busy_m},  32'h0);
        check("rst_store_done", {31'h0, done_m},  32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming from the lower buffer
        run_tile(1'b0, 0, 0, 0, 0);
        check_words("stream", 16'h0100);
        check("stream_first_re",    32'(first_re),    32'd1);
        check("stream_busy_c1",     {31'h0, busy_c1}, 32'h1);
        check("stream_first_valid", 32'(first_valid), 32'd3);
        check("stream_last_idx",    32'(last_idx),    32'd7);
        check("stream_done_cyc",    32'(done_cyc),    32'd11);
        check("stream_done_cnt",    32'(done_cnt),    32'd1);
        check("stream_gapless",     32'(acc_q.size() == 8 ? acc_q[7] - acc_q[0] : -1), 32'd7);

        // Upper buffer
        run_tile(1'b1, 0, 0, 0, 0);
        check_words("upper", 16'h0108);
        check("upper_reads", 32'(ra_q.size()), 32'd8);
        for (int i = 0; i < ra_q.size() && i < 8; i++) begin
            check($sformatf("upper_raddr%0d", i), {28'h0, ra_q[i]}, 32'(8 + i));
        end
        check("upper_last_idx", 32'(last_idx), 32'd7);

        // Backpressure over cycles 3..10
        run_tile(1'b0, 3, 10, 0, 0);
        check_words("bp", 16'h0100);
        check("bp_stall_re",  32'(stall_re), 32'd0);
        check("bp_held_data", 32'(held_bad), 32'd0);
        check("bp_reads",     32'(ra_q.size()), 32'd8);
        check("bp_done_cnt",  32'(done_cnt), 32'd1);
        check("bp_last_idx",  32'(last_idx), 32'd7);

        // Restart request in the middle of a tile
        run_tile(1'b0, 0, 0, 5, 0);
        check_words("restart", 16'h0100);
        check("restart_done_cnt", 32'(done_cnt),    32'd1);
        check("restart_reads",    32'(ra_q.size()), 32'd8);
        check("restart_done_cyc", 32'(done_cyc),    32'd11);

        // Reset after three words
        run_tile(1'b1, 0, 0, 0, 3);
        check("mid_pre_words", 32'(got_q.size()), 32'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_bram_re",    {31'h0, re_m},    32'h0);
        check("mid_raddr",      {28'h0, raddr_m}, 32'h0);
        check("mid_out_valid",  {31'h0, valid_m}, 32'h0);
        check("mid_out_data",   {16'h0, data_m},  32'h0);
        check("mid_out_last",   {31'h0, last_m},  32'h0);
        check("mid_busy",       {31'h0, busy_m},  32'h0);
        check("mid_store_done", {31'h0, done_m},  32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_idle_valid", {31'h0, valid_m}, 32'h0);
        run_tile(1'b0, 0, 0, 0, 0);
        check_words("post_rst", 16'h0100);
        check("post_rst_done_cyc", 32'(done_cyc), 32'd11);

        // Read latency 3
        use3 = 1'b1;
        @(posedge clk); #1;
        run_tile(1'b0, 0, 0, 0, 0);
        check_words("lat3", 16'h0100);
        check("lat3_first_valid", 32'(first_valid), 32'd5);
        check("lat3_gapless",     32'(acc_q.size() == 8 ? acc_q[7] - acc_q[0] : -1), 32'd7);
        check("lat3_done_cyc",    32'(done_cyc),    32'd13);
        check("lat3_last_idx",    32'(last_idx),    32'd7);
        check("lat3_done_cnt",    32'(done_cnt),    32'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
